imuldiv_div_requester: RTL and testbench



---
 rtl/imuldiv_pkg.sv | 37 +++
 rtl/imuldiv_WaitTimer.sv | 38 +++
 rtl/imuldiv_div_requester.sv | 138 +++++++++++++
 tb/tb_imuldiv_div_requester.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_pkg.sv
// imuldiv_pkg
//   Shared encodings for the iterative multiply/divide unit. The divide
//   requester and the divider request message both use these definitions.
//   Contents:
//     divreq_state_t  requester FSM state encoding
//     div_fn_t        divider function encoding (carried on divreq_msg_fn)
//     div_sel_t       which half of the divider result to forward
//     DIV_ALL_ONES    result word used for timeouts and zero-divisor quotients
//     select_result   picks quotient or remainder out of a divider response
package imuldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } divreq_state_t;

  typedef enum logic {
    DIV_FN_UNSIGNED = 1'b0,
    DIV_FN_SIGNED   = 1'b1
  } div_fn_t;

  typedef enum logic {
    DIV_SEL_QUOT = 1'b0,
    DIV_SEL_REM  = 1'b1
  } div_sel_t;

  localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

  // Divider response layout: [63:32] remainder, [31:0] quotient.
  function automatic logic [31:0] select_result(input logic sel,
                                                input logic [63:0] result);
    return (sel == DIV_SEL_REM) ? result[63:32] : result[31:0];
  endfunction

endpackage

// File: rtl/imuldiv_WaitTimer.sv
// imuldiv_WaitTimer
//   Response wait timer for the divide requester. Counts enabled cycles from
//   zero and flags expiry once the count reaches LIMIT-1; the count then holds
//   until cleared.
//   Ports:
//     clk      clock
//     reset    async active-high reset, clears the count
//     clear    synchronous clear to zero (priority over enable)
//     enable   advance the count this cycle
//     expired  high while count == LIMIT-1
module imuldiv_WaitTimer #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  assign expired = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/imuldiv_div_requester.sv
// imuldiv_div_requester
//   Accepts one divide operation at a time, issues it to the iterative
//   divider, waits (bounded by TIMEOUT_CYCLES) for the response and presents
//   the selected quotient or remainder downstream.
//
//   Optional feature: define IMULDIV_DIVREQ_ZERO_BYPASS_EN to answer a zero
//   divisor locally (quotient all ones, remainder = dividend) without
//   involving the divider.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new op (op_rdy)
//   ISSUE | request held on divreq_* until the divider takes it
//   WAIT  | waiting for divresp_val, wait timer running
//   DONE  | result held on res_* until downstream takes it
//
//   Ports:
//     clk, reset                 clock, async active-high reset
//     op_val/op_rdy              upstream op handshake
//     op_fn, op_sel, op_a, op_b  signedness, quotient/remainder select, operands
//     divreq_val/divreq_rdy      divider request handshake
//     divreq_msg_fn/_a/_b        latched operands sent to the divider
//     divresp_val/divresp_rdy    divider response handshake
//     divresp_msg_result         {remainder, quotient}
//     res_val/res_rdy            downstream result handshake
//     res_data, res_err          selected result, timeout flag
//     busy                       any state other than IDLE
module imuldiv_div_requester
  import imuldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_val,
  output logic        op_rdy,
  input  logic        op_fn,
  input  logic        op_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  input  logic        divresp_val,
  output logic        divresp_rdy,
  input  logic [63:0] divresp_msg_result,
  output logic        res_val,
  input  logic        res_rdy,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        busy
);

  divreq_state_t state;
  logic          sel_q;
  logic          timer_clear;
  logic          timer_expired;

  // Handshake outputs come straight from the state register only.
  assign op_rdy      = (state == ST_IDLE);
  assign divreq_val  = (state == ST_ISSUE);
  assign divresp_rdy = (state == ST_WAIT);
  assign res_val     = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);

  // Restart the count on the request handshake so WAIT always starts at 0.
  assign timer_clear = (state == ST_ISSUE) && divreq_rdy;

  imuldiv_WaitTimer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (state == ST_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel_q         <= 1'b0;
      divreq_msg_fn <= 1'b0;
      divreq_msg_a  <= '0;
      divreq_msg_b  <= '0;
      res_data      <= '0;
      res_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_val) begin
            sel_q         <= op_sel;
            divreq_msg_fn <= op_fn;
            divreq_msg_a  <= op_a;
            divreq_msg_b  <= op_b;
`ifdef IMULDIV_DIVREQ_ZERO_BYPASS_EN
            if (op_b == '0) begin
              res_data <= (op_sel == DIV_SEL_REM) ? op_a : DIV_ALL_ONES;
              res_err  <= 1'b0;
              state    <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
`else
            state <= ST_ISSUE;
`endif
          end
        end
        ST_ISSUE: begin
          if (divreq_rdy) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response in the expiry cycle still counts as a good answer.
          if (divresp_val) begin
            res_data <= select_result(sel_q, divresp_msg_result);
            res_err  <= 1'b0;
            state    <= ST_DONE;
          end else if (timer_expired) begin
            res_data <= DIV_ALL_ONES;
            res_err  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_rdy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_div_requester.sv
module tb_imuldiv_div_requester;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_val, op_rdy, op_fn, op_sel;
  logic [31:0] op_a, op_b;
  logic        divreq_val, divreq_rdy, divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divresp_val, divresp_rdy;
  logic [63:0] divresp_msg_result;
  logic        res_val, res_rdy, res_err, busy;
  logic [31:0] res_data;

  imuldiv_div_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .op_val(op_val), .op_rdy(op_rdy), .op_fn(op_fn), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
    .divreq_msg_b(divreq_msg_b),
    .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .divresp_msg_result(divresp_msg_result),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: one op in flight plus the values it must produce.
  bit          inflight = 1'b0;
  logic        exp_fn;
  logic [31:0] exp_a, exp_b, exp_data;
  logic        exp_err;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference divider: RISC-V style answers for zero divisor and overflow.
  function automatic logic [63:0] div_model(input logic fn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (fn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Per-cycle compare process.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("rst_op_rdy", {31'd0, op_rdy}, 32'd1);
        check("rst_divreq_val", {31'd0, divreq_val}, 32'd0);
        check("rst_divresp_rdy", {31'd0, divresp_rdy}, 32'd0);
        check("rst_res_val", {31'd0, res_val}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
      end else begin
        check("onehot", $countones({op_rdy, divreq_val, divresp_rdy, res_val}), 32'd1);
        check("op_rdy", {31'd0, op_rdy}, {31'd0, !inflight});
        check("busy", {31'd0, busy}, {31'd0, inflight});
        if (inflight && divreq_val) begin
          check("req_fn", {31'd0, divreq_msg_fn}, {31'd0, exp_fn});
          check("req_a", divreq_msg_a, exp_a);
          check("req_b", divreq_msg_b, exp_b);
        end
        if (inflight && res_val) begin
          check("res_data", res_data, exp_data);
          check("res_err", {31'd0, res_err}, {31'd0, exp_err});
        end
      end
    end
  end

  // One op end to end. resp_d < 0 means the divider never answers;
  // abort_at >= 0 asserts reset in that WAIT cycle instead of completing.
  task automatic run_op(input logic fn, input logic sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input int req_d, input int resp_d, input int res_d,
                        input bit pin_en, input logic [31:0] pin_data,
                        input logic pin_err, input int pin_lat,
                        input int abort_at);
    logic [63:0] resp;
    bit bypass, timeout, seen_res, saw_req, done;
    int exp_lat, cyc, icnt, wcnt, dcnt, n;
    resp = div_model(fn, a, b);
    bypass = 1'b0;
`ifdef IMULDIV_DIVREQ_ZERO_BYPASS_EN
    bypass = (b == 32'd0);
`endif
    timeout = !bypass && (resp_d < 0 || resp_d > TO - 1);
    exp_fn = fn; exp_a = a; exp_b = b;
    exp_err = timeout;
    if (bypass) exp_data = sel ? a : 32'hFFFF_FFFF;
    else if (timeout) exp_data = 32'hFFFF_FFFF;
    else exp_data = sel ? resp[63:32] : resp[31:0];
    exp_lat = bypass ? 1 : 1 + (req_d + 1) + (timeout ? TO : resp_d + 1);

    n = 0;
    @(negedge clk);
    while (!op_rdy && n < 50) begin @(negedge clk); n++; end
    if (!op_rdy) begin
      check("op_rdy_timeout", {31'd0, op_rdy}, 32'd1);
      return;
    end
    op_val = 1'b1; op_fn = fn; op_sel = sel; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    inflight = 1'b1;
    op_val = 1'b0; op_fn = $urandom; op_sel = $urandom; op_a = $urandom; op_b = $urandom;

    cyc = 0; icnt = 0; wcnt = 0; dcnt = 0;
    seen_res = 0; saw_req = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        check("op_cycle_budget", cyc, 400);
        break;
      end
      if (abort_at >= 0 && divresp_rdy && wcnt == abort_at) begin
        reset = 1'b1;
        divreq_rdy = 1'b0; divresp_val = 1'b0; res_rdy = 1'b0;
        #1;
        inflight = 1'b0;
        check("abort_op_rdy", {31'd0, op_rdy}, 32'd1);
        check("abort_divresp_rdy", {31'd0, divresp_rdy}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_res_data", res_data, 32'd0);
        check("abort_req_a", divreq_msg_a, 32'd0);
        check("abort_req_b", divreq_msg_b, 32'd0);
        check("abort_req_fn", {31'd0, divreq_msg_fn}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_op_rdy", {31'd0, op_rdy}, 32'd1);
        return;
      end
      if (divreq_val) begin
        saw_req = 1;
        divreq_rdy = (icnt >= req_d);
        icnt++;
      end else begin
        divreq_rdy = $urandom;
      end
      if (divresp_rdy) begin
        divresp_val = (resp_d >= 0 && wcnt == resp_d);
        divresp_msg_result = divresp_val ? resp : {$urandom, $urandom};
        wcnt++;
      end else begin
        divresp_val = ($urandom_range(3) == 0);
        divresp_msg_result = {$urandom, $urandom};
      end
      if (res_val) begin
        if (!seen_res) begin
          seen_res = 1;
          check("latency", cyc, exp_lat);
          if (pin_en) begin
            check("pin_data", res_data, pin_data);
            check("pin_err", {31'd0, res_err}, {31'd0, pin_err});
            check("pin_latency", cyc, pin_lat);
          end
        end
        res_rdy = (dcnt >= res_d);
        dcnt++;
        if (res_rdy) done = 1;
      end else begin
        res_rdy = $urandom;
      end
    end
    if (bypass) check("bypass_no_req", {31'd0, saw_req}, 32'd0);
    @(posedge clk);
    #1;
    inflight = 1'b0;
    res_rdy = 1'b0; divreq_rdy = 1'b0; divresp_val = 1'b0;
  endtask

  initial begin
    int rd, rsel;
    logic [31:0] rb;
    reset = 1'b1;
    op_val = 0; op_fn = 0; op_sel = 0; op_a = 0; op_b = 0;
    divreq_rdy = 0; divresp_val = 0; divresp_msg_result = '0; res_rdy = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Unsigned 100/7, answer after 33 WAIT cycles.
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 0, 32, 0, 1, 32'd14, 1'b0, 35, -1);
    // Signed -100 % 7, request stalled 2 cycles.
    run_op(1'b1, 1'b1, -32'sd100, 32'd7, 2, 0, 1, 1, 32'hFFFF_FFFE, 1'b0, 5, -1);
    // Backpressure on both sides.
    run_op(1'b0, 1'b0, 32'd1000, 32'd10, 5, 0, 4, 1, 32'd100, 1'b0, 8, -1);
    // No response: timeout.
    run_op(1'b0, 1'b0, 32'd5, 32'd3, 0, -1, 0, 1, 32'hFFFF_FFFF, 1'b1, 66, -1);
    // Response in the expiry cycle wins.
    run_op(1'b0, 1'b1, 32'd77, 32'd5, 0, TO - 1, 0, 1, 32'd2, 1'b0, 66, -1);
    // Zero divisor, remainder select.
`ifdef IMULDIV_DIVREQ_ZERO_BYPASS_EN
    run_op(1'b0, 1'b1, 32'd42, 32'd0, 0, 0, 0, 1, 32'd42, 1'b0, 1, -1);
`else
    run_op(1'b0, 1'b1, 32'd42, 32'd0, 0, 0, 0, 1, 32'd42, 1'b0, 3, -1);
`endif
    // Reset in WAIT, then a normal op.
    run_op(1'b0, 1'b0, 32'd500, 32'd3, 0, -1, 0, 0, 32'd0, 1'b0, 0, 5);
    run_op(1'b0, 1'b0, 32'd500, 32'd3, 0, 0, 0, 1, 32'd166, 1'b0, 3, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: rb = $urandom_range(9, 1);
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      rsel = $urandom_range(9);
      if (rsel == 0) rd = -1;
      else if (rsel == 1) rd = TO - 1;
      else if (rsel == 2) rd = TO - 2;
      else rd = $urandom_range(11);
      run_op($urandom, $urandom, (i % 5 == 0) ? 32'h8000_0000 : $urandom, rb,
             $urandom_range(3), rd, $urandom_range(3),
             0, 32'd0, 1'b0, 0, -1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
